// File: rtl/dual_rail_pkg.sv
// Shared types and constants for the dual-rail function unit.
// The reset table FIG1_TT reproduces the original fixed four-input complex gate.
package dual_rail_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    LOAD = 1'b1
  } state_t;

  localparam int unsigned ERR_CNT_W = 8;
  localparam logic [15:0] FIG1_TT   = 16'hFC51;

  // A pair is valid only when its rails disagree; bits at or above n are ignored.
  function automatic logic rails_ok(input logic [5:0] true_r,
                                    input logic [5:0] comp_r,
                                    input int unsigned n);
    logic ok;
    ok = 1'b1;
    for (int unsigned k = 0; k < 6; k++) begin
      if (k < n && true_r[k] == comp_r[k]) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/dual_rail_func_unit_rail_check.sv
// Combinational rail-validity check: every true/complement pair must differ.
module dr_rail_check #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0] in_true,
  input  logic [N-1:0] in_comp,
  output logic         ok
);

  assign ok = &(in_true ^ in_comp);

endmodule

// File: rtl/dual_rail_func_unit.sv
// Runtime-programmable N-input dual-rail function unit with a registered,
// valid/ready output stage, sticky rail-error reporting and serial table load.
module dual_rail_func_unit
  import dual_rail_pkg::*;
#(
  parameter int unsigned         N          = 4,
  parameter logic [(1<<N)-1:0]   DEFAULT_TT = FIG1_TT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N-1:0]         in_true,
  input  logic [N-1:0]         in_comp,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out,
  output logic                 rail_err,
  output logic [ERR_CNT_W-1:0] err_count,
  input  logic                 err_clr,
  input  logic                 tt_load_start,
  input  logic                 tt_load_bit,
  output logic                 tt_busy
);

  localparam int unsigned TT_W  = 1 << N;
  localparam int unsigned CNT_W = N + 1;

  state_t           state, state_nxt;
  logic [TT_W-1:0]  tt;
  logic [CNT_W-1:0] bit_cnt;
  logic             pair_ok;
  logic             accept;
  logic             err_new;
  logic             load_last;

  dr_rail_check #(.N(N)) u_rail_check (
    .in_true (in_true),
    .in_comp (in_comp),
    .ok      (pair_ok)
  );

  assign accept    = in_valid && in_ready;
  assign err_new   = accept && !pair_ok;
  assign load_last = (bit_cnt == CNT_W'(TT_W - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) state <= RUN;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    tt_busy   = 1'b0;
    case (state)
      RUN: begin
        in_ready = !out_valid || out_ready;
        if (tt_load_start) state_nxt = LOAD;
      end
      LOAD: begin
        tt_busy = 1'b1;
        if (load_last) state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  // Table shifts MSB-first; after TT_W shifts the first bit sent sits at the top index.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tt      <= DEFAULT_TT;
      bit_cnt <= '0;
    end else if (state == RUN) begin
      if (tt_load_start) bit_cnt <= '0;
    end else begin
      tt      <= {tt[TT_W-2:0], tt_load_bit};
      bit_cnt <= bit_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out       <= 1'b0;
    end else if (accept && pair_ok) begin
      out_valid <= 1'b1;
      out       <= tt[in_true];
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // A fresh error outranks a simultaneous clear, restarting the count at one.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rail_err  <= 1'b0;
      err_count <= '0;
    end else if (err_new) begin
      rail_err <= 1'b1;
      if (err_clr)             err_count <= ERR_CNT_W'(1);
      else if (err_count != '1) err_count <= err_count + 1'b1;
    end else if (err_clr) begin
      rail_err  <= 1'b0;
      err_count <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && in_valid) begin
      assert (pair_ok == rails_ok(6'(in_true), 6'(in_comp), N));
    end
  end

endmodule

// File: tb/tb_dual_rail_func_unit.sv
// Self-checking bench for dual_rail_func_unit (N=4) against a behavioural
// model: a 16-entry truth table, a one-entry result holder and an error tally.
module tb_dual_rail_func_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_true;
  logic [3:0] in_comp;
  logic       out_valid;
  logic       out_ready;
  logic       out;
  logic       rail_err;
  logic [7:0] err_count;
  logic       err_clr;
  logic       tt_load_start;
  logic       tt_load_bit;
  logic       tt_busy;

  int n_cmp = 0;
  int n_bad = 0;

  bit   model_tt [16];
  bit   m_valid;
  bit   m_out;
  bit   m_err;
  int   m_cnt;

  always #5 clk = ~clk;

  dual_rail_func_unit #(.N(4), .DEFAULT_TT(16'hFC51)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_true       (in_true),
    .in_comp       (in_comp),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out           (out),
    .rail_err      (rail_err),
    .err_count     (err_count),
    .err_clr       (err_clr),
    .tt_load_start (tt_load_start),
    .tt_load_bit   (tt_load_bit),
    .tt_busy       (tt_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_model_table(input logic [15:0] v);
    for (int i = 0; i < 16; i++) model_tt[i] = v[i];
  endtask

  task automatic drive_idle();
    in_valid      = 1'b0;
    in_true       = 4'h0;
    in_comp       = 4'hF;
    out_ready     = 1'b1;
    err_clr       = 1'b0;
    tt_load_start = 1'b0;
    tt_load_bit   = 1'b0;
  endtask

  task automatic drive_op(input logic [3:0] t);
    in_valid = 1'b1;
    in_true  = t;
    in_comp  = ~t;
  endtask

  task automatic test_reset();
    drive_idle();
    rst_n = 1'b0;
    tick();
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_cmp++; if (out !== 1'b0)       begin n_bad++; $display("FAIL reset_out got %b want 0", out); end
    n_cmp++; if (in_ready !== 1'b1)  begin n_bad++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_cmp++; if (rail_err !== 1'b0)  begin n_bad++; $display("FAIL reset_rail_err got %b want 0", rail_err); end
    n_cmp++; if (err_count !== 8'd0) begin n_bad++; $display("FAIL reset_err_count got %0d want 0", err_count); end
    n_cmp++; if (tt_busy !== 1'b0)   begin n_bad++; $display("FAIL reset_tt_busy got %b want 0", tt_busy); end
    rst_n = 1'b1;
    set_model_table(16'hFC51);
    tick();
  endtask

  task automatic test_default_function();
    logic [3:0] ops [3] = '{4'b0000, 4'b0001, 4'b1010};
    bit         exp [3] = '{1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      drive_op(ops[i]);
      tick();
      n_cmp++; if (out_valid !== 1'b1 || out !== exp[i]) begin
        n_bad++; $display("FAIL fig1_op%b got v=%b o=%b want v=1 o=%b", ops[i], out_valid, out, exp[i]);
      end
    end
    drive_idle();
    tick();
  endtask

  task automatic test_back_to_back();
    logic [3:0] t;
    for (int i = 0; i < 40; i++) begin
      t = 4'($urandom_range(0, 15));
      drive_op(t);
      #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready[%0d] got %b want 1", i, in_ready); end
      tick();
      n_cmp++; if (out_valid !== 1'b1 || out !== model_tt[t]) begin
        n_bad++; $display("FAIL b2b_result[%0d] op=%h got v=%b o=%b want v=1 o=%b", i, t, out_valid, out, model_tt[t]);
      end
    end
    drive_idle();
    tick();
  endtask

  task automatic test_errors();
    logic [3:0] t;
    int         want;
    in_valid = 1'b1; in_true = 4'b0011; in_comp = 4'b0111;
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL err_no_result got %b want 0", out_valid); end
    n_cmp++; if (rail_err !== 1'b1)  begin n_bad++; $display("FAIL err_flag got %b want 1", rail_err); end
    n_cmp++; if (err_count !== 8'd1) begin n_bad++; $display("FAIL err_count1 got %0d want 1", err_count); end
    want = 1;
    for (int i = 0; i < 300; i++) begin
      t = 4'($urandom_range(0, 15));
      in_true = t;
      in_comp = ~t ^ (4'b0001 << $urandom_range(0, 3));
      tick();
      want = (want < 255) ? want + 1 : 255;
      if (i == 253 || i == 254) begin
        n_cmp++; if (err_count !== 8'(want)) begin n_bad++; $display("FAIL err_count_near_sat got %0d want %0d", err_count, want); end
      end
    end
    n_cmp++; if (err_count !== 8'd255) begin n_bad++; $display("FAIL err_count_sat got %0d want 255", err_count); end
    n_cmp++; if (out_valid !== 1'b0)   begin n_bad++; $display("FAIL err_no_result_run got %b want 0", out_valid); end
    drive_idle();
    err_clr = 1'b1;
    tick();
    n_cmp++; if (rail_err !== 1'b0 || err_count !== 8'd0) begin
      n_bad++; $display("FAIL err_clr got flag=%b cnt=%0d want 0/0", rail_err, err_count);
    end
    in_valid = 1'b1; in_true = 4'b0101; in_comp = 4'b0100;
    tick();
    tick();
    in_true = 4'b1100; in_comp = 4'b1100;
    err_clr = 1'b1;
    tick();
    n_cmp++; if (rail_err !== 1'b1 || err_count !== 8'd1) begin
      n_bad++; $display("FAIL err_clr_vs_new got flag=%b cnt=%0d want 1/1", rail_err, err_count);
    end
    drive_idle();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [3:0] a, b;
    a = 4'($urandom_range(0, 15));
    b = ~a;
    out_ready = 1'b0;
    drive_op(a);
    tick();
    n_cmp++; if (out_valid !== 1'b1 || out !== model_tt[a]) begin
      n_bad++; $display("FAIL bp_first got v=%b o=%b want v=1 o=%b", out_valid, out, model_tt[a]);
    end
    drive_op(b);
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_ready_low[%0d] got %b want 0", i, in_ready); end
      tick();
      n_cmp++; if (out_valid !== 1'b1 || out !== model_tt[a]) begin
        n_bad++; $display("FAIL bp_hold[%0d] got v=%b o=%b want v=1 o=%b", i, out_valid, out, model_tt[a]);
      end
    end
    out_ready = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_ready_rise got %b want 1", in_ready); end
    tick();
    n_cmp++; if (out_valid !== 1'b1 || out !== model_tt[b]) begin
      n_bad++; $display("FAIL bp_second got v=%b o=%b want v=1 o=%b", out_valid, out, model_tt[b]);
    end
    drive_idle();
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_drain got %b want 0", out_valid); end
  endtask

  task automatic test_load(input logic [15:0] v);
    logic [3:0] t;
    drive_idle();
    tt_load_start = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) begin
      t = 4'($urandom_range(0, 15));
      drive_op(t);
      tt_load_start = 1'($urandom_range(0, 1));
      tt_load_bit   = v[15 - i];
      #1;
      n_cmp++; if (tt_busy !== 1'b1 || in_ready !== 1'b0) begin
        n_bad++; $display("FAIL load_busy[%0d] got busy=%b rdy=%b want 1/0", i, tt_busy, in_ready);
      end
      tick();
    end
    drive_idle();
    set_model_table(v);
    n_cmp++; if (tt_busy !== 1'b0 || out_valid !== 1'b0) begin
      n_bad++; $display("FAIL load_end got busy=%b v=%b want 0/0", tt_busy, out_valid);
    end
    for (int i = 0; i < 16; i++) begin
      drive_op(4'(i));
      tick();
      n_cmp++; if (out_valid !== 1'b1 || out !== model_tt[i]) begin
        n_bad++; $display("FAIL load_table tt=%h op=%0d got o=%b want %b", v, i, out, model_tt[i]);
      end
    end
    drive_idle();
    tick();
  endtask

  task automatic test_reset_mid_load();
    drive_idle();
    tt_load_start = 1'b1;
    tick();
    tt_load_start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tt_load_bit = 1'($urandom_range(0, 1));
      tick();
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    set_model_table(16'hFC51);
    m_err = 1'b0; m_cnt = 0;
    n_cmp++; if (tt_busy !== 1'b0) begin n_bad++; $display("FAIL midload_busy got %b want 0", tt_busy); end
    drive_op(4'b0000);
    tick();
    n_cmp++; if (out_valid !== 1'b1 || out !== 1'b1) begin
      n_bad++; $display("FAIL midload_op0 got v=%b o=%b want 1/1", out_valid, out);
    end
    drive_op(4'b0001);
    tick();
    n_cmp++; if (out !== 1'b0) begin n_bad++; $display("FAIL midload_op1 got %b want 0", out); end
    drive_idle();
    tick();
  endtask

  task automatic test_load_collision();
    logic [15:0] v;
    logic [3:0]  t;
    v = 16'($urandom);
    t = 4'($urandom_range(0, 15));
    drive_op(t);
    tt_load_start = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL coll_ready got %b want 1", in_ready); end
    tick();
    n_cmp++; if (out_valid !== 1'b1 || out !== model_tt[t] || tt_busy !== 1'b1) begin
      n_bad++; $display("FAIL coll_old_table got v=%b o=%b busy=%b want 1/%b/1", out_valid, out, tt_busy, model_tt[t]);
    end
    drive_idle();
    for (int i = 0; i < 16; i++) begin
      tt_load_bit = v[15 - i];
      tick();
    end
    set_model_table(v);
    for (int i = 0; i < 4; i++) begin
      t = 4'($urandom_range(0, 15));
      drive_op(t);
      tick();
      n_cmp++; if (out !== model_tt[t]) begin
        n_bad++; $display("FAIL coll_new_table op=%h got %b want %b", t, out, model_tt[t]);
      end
    end
    drive_idle();
    tick();
  endtask

  task automatic test_random_mix();
    bit         exp_ready, acc, good;
    logic [3:0] t, c;
    drive_idle();
    err_clr = 1'b1;
    tick();
    m_valid = 1'b0; m_out = 1'b0; m_err = 1'b0; m_cnt = 0;
    for (int i = 0; i < 200; i++) begin
      t = 4'($urandom_range(0, 15));
      c = ($urandom_range(0, 4) == 0) ? (~t ^ (4'b0001 << $urandom_range(0, 3))) : ~t;
      in_valid  = 1'($urandom_range(0, 1));
      in_true   = t;
      in_comp   = c;
      out_ready = 1'($urandom_range(0, 2) != 0);
      err_clr   = ($urandom_range(0, 15) == 0);
      exp_ready = !m_valid || out_ready;
      #1;
      n_cmp++; if (in_ready !== exp_ready) begin n_bad++; $display("FAIL mix_ready[%0d] got %b want %b", i, in_ready, exp_ready); end
      acc  = in_valid && exp_ready;
      good = ((t ^ c) == 4'hF);
      if (acc && good) begin m_valid = 1'b1; m_out = model_tt[t]; end
      else if (out_ready) m_valid = 1'b0;
      if (acc && !good) begin
        m_err = 1'b1;
        m_cnt = err_clr ? 1 : ((m_cnt < 255) ? m_cnt + 1 : 255);
      end else if (err_clr) begin
        m_err = 1'b0; m_cnt = 0;
      end
      tick();
      n_cmp++; if (out_valid !== m_valid || (m_valid && out !== m_out)) begin
        n_bad++; $display("FAIL mix_out[%0d] got v=%b o=%b want v=%b o=%b", i, out_valid, out, m_valid, m_out);
      end
      n_cmp++; if (rail_err !== m_err || err_count !== 8'(m_cnt)) begin
        n_bad++; $display("FAIL mix_err[%0d] got f=%b c=%0d want f=%b c=%0d", i, rail_err, err_count, m_err, m_cnt);
      end
    end
    drive_idle();
    tick();
  endtask

  initial begin
    test_reset();
    test_default_function();
    test_back_to_back();
    test_errors();
    test_backpressure();
    test_load(16'h8000);
    test_reset_mid_load();
    test_load_collision();
    test_load(16'($urandom));
    test_random_mix();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
